// File: rtl/aes_128_req_sched.sv
// Round-robin front end that time-shares a single AES-128 core between NUM_REQ
// block requesters and returns each ciphertext tagged with its requester index.
module aes_128_req_sched #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       kill,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*128-1:0]     req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [127:0]               core_in_data,
    output logic                       core_in_en,
    input  logic                       core_idle,
    input  logic [127:0]               core_out_data,
    input  logic                       core_out_en,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [127:0]               rsp_data,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic                       busy,
    output logic                       err_timeout,
    output logic                       err_spurious,
    output logic [15:0]                blk_cnt
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]                  state;
    logic [IW-1:0]               last_grant;
    logic [IW-1:0]               tag_q;
    logic [CW-1:0]               cnt;
    logic [NUM_REQ-1:0][127:0]   req_blk;
    logic [IW-1:0]               gnt_idx;
    logic [IW-1:0]               cand;
    logic                        gnt_found;
    logic                        hs;

    assign req_blk = req_data;

    // Rotating priority: scan from the slot after the last winner, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((int'(last_grant) + i) % NUM_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign hs         = (state == S_IDLE) && core_idle && gnt_found;
    assign req_ready  = hs ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign core_in_en = (state == S_ISSUE);
    assign rsp_valid  = (state == S_HOLD);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (kill) begin
            state        <= S_IDLE;
            last_grant   <= IW'(NUM_REQ - 1);
            tag_q        <= '0;
            cnt          <= '0;
            core_in_data <= '0;
            rsp_data     <= '0;
            rsp_id       <= '0;
            blk_cnt      <= '0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            err_timeout  <= 1'b0;
            // A result outside WAIT has no owner; flag it and leave state alone.
            err_spurious <= core_out_en && (state != S_WAIT);
            case (state)
                S_IDLE: begin
                    if (hs) begin
                        core_in_data <= req_blk[gnt_idx];
                        tag_q        <= gnt_idx;
                        last_grant   <= gnt_idx;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt != CNT_MAX)
                        cnt <= cnt + CW'(1);
                    // A result arriving on the last allowed cycle still counts.
                    if (core_out_en) begin
                        rsp_data <= core_out_data;
                        rsp_id   <= tag_q;
                        blk_cnt  <= blk_cnt + 16'd1;
                        state    <= S_HOLD;
                    end else if (cnt == CNT_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    if (rsp_ready)
                        state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_128_req_sched.sv
// Directed bench for aes_128_req_sched: a behavioural core stand-in with
// programmable latency, a round-robin vector table and hand-written corner cases.
module tb_aes_128_req_sched;

    localparam int NR = 4;
    localparam int TO = 8;
    localparam logic [127:0] PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] XK   = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] SPUR = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

    logic                 clk = 1'b0;
    logic                 kill;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0][127:0] rdata;
    logic [NR*128-1:0]    req_data;
    logic [NR-1:0]        req_ready;
    logic [127:0]         core_in_data;
    logic                 core_in_en;
    logic                 core_idle;
    logic [127:0]         core_out_data;
    logic                 core_out_en;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [127:0]         rsp_data;
    logic [1:0]           rsp_id;
    logic                 busy;
    logic                 err_timeout;
    logic                 err_spurious;
    logic [15:0]          blk_cnt;

    assign req_data = rdata;

    aes_128_req_sched #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk(clk), .kill(kill), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .core_in_data(core_in_data), .core_in_en(core_in_en),
        .core_idle(core_idle), .core_out_data(core_out_data), .core_out_en(core_out_en),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .busy(busy), .err_timeout(err_timeout), .err_spurious(err_spurious), .blk_cnt(blk_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] exp_ct(input logic [127:0] x);
        return (x == PT) ? CT : (x ^ XK);
    endfunction

    // Core stand-in: answers core_lat cycles after core_in_en (core_lat >= 2), or never when 0.
    int           core_lat;
    int           cd;
    logic [127:0] pend;
    logic [127:0] mdl_data;
    logic         mdl_en;
    logic         spur;
    initial begin
        cd = 0; mdl_en = 1'b0; mdl_data = '0; pend = '0;
    end
    always @(posedge clk) begin
        mdl_en <= 1'b0;
        if (core_in_en) begin
            cd   <= core_lat;
            pend <= core_in_data;
        end else if (cd == 2) begin
            cd       <= 0;
            mdl_en   <= 1'b1;
            mdl_data <= exp_ct(pend);
        end else if (cd > 2) begin
            cd <= cd - 1;
        end
    end
    assign core_out_en   = mdl_en | spur;
    assign core_out_data = spur ? SPUR : mdl_data;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_blk = 0;

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [282:0] outs();
        return {req_ready, core_in_en, core_in_data, rsp_valid, rsp_data, rsp_id,
                busy, err_timeout, err_spurious, blk_cnt};
    endfunction

    task automatic wait_ready(input string nm);
        int k = 0;
        #1;
        while (req_ready == '0 && k < 64) begin
            step();
            k++;
        end
        check({nm, " ready_seen"}, 512'(req_ready != '0), 512'(1));
    endtask

    task automatic wait_rsp(input string nm, output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 64) begin
            step();
            cyc++;
        end
        check({nm, " rsp_seen"}, 512'(rsp_valid), 512'(1));
    endtask

    task automatic run_txn(input string nm, input logic [3:0] mask, input logic [3:0] rdy, input int id);
        int cyc;
        req_valid = mask;
        wait_ready(nm);
        check({nm, " req_ready"}, 512'(req_ready), 512'(rdy));
        step();
        check({nm, " core_in_data"}, 512'(core_in_data), 512'(rdata[id]));
        wait_rsp(nm, cyc);
        check({nm, " rsp_id"}, 512'(rsp_id), 512'(id));
        check({nm, " rsp_data"}, 512'(rsp_data), 512'(exp_ct(rdata[id])));
        exp_blk++;
    endtask

    typedef struct {
        logic [3:0] mask;
        logic [3:0] rdy;
        int         id;
    } vec_t;
    vec_t tbl [14];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int cyc, n, bad_a, bad_b, bad_c;
        logic [127:0] snap_d;
        logic [1:0]   snap_id;

        tbl[0]  = '{4'hF, 4'b0001, 0};  tbl[1]  = '{4'hF, 4'b0010, 1};
        tbl[2]  = '{4'hF, 4'b0100, 2};  tbl[3]  = '{4'hF, 4'b1000, 3};
        tbl[4]  = '{4'hF, 4'b0001, 0};  tbl[5]  = '{4'hF, 4'b0010, 1};
        tbl[6]  = '{4'hF, 4'b0100, 2};  tbl[7]  = '{4'hF, 4'b1000, 3};
        tbl[8]  = '{4'b1010, 4'b0010, 1}; tbl[9]  = '{4'b1010, 4'b1000, 3};
        tbl[10] = '{4'b0001, 4'b0001, 0}; tbl[11] = '{4'b0110, 4'b0010, 1};
        tbl[12] = '{4'b1001, 4'b1000, 3}; tbl[13] = '{4'b1001, 4'b0001, 0};

        rdata[0] = 128'h00112233445566778899aabbccddeeff;
        rdata[1] = 128'h0123456789abcdeffedcba9876543210;
        rdata[2] = PT;
        rdata[3] = 128'hcafef00dcafef00d1234567812345678;

        kill = 1'b1; req_valid = '0; rsp_ready = 1'b0; core_idle = 1'b1;
        spur = 1'b0; core_lat = 4;
        step(); step(); step();
        check("reset outputs", 512'(outs()), 512'(0));
        kill = 1'b0;

        // Single request from requester 2 with the reference block.
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        wait_ready("single");
        check("single req_ready", 512'(req_ready), 512'(4'b0100));
        step();
        check("single ready_drop", 512'(req_ready), 512'(0));
        check("single core_in_en", 512'(core_in_en), 512'(1));
        check("single core_in_data", 512'(core_in_data), 512'(PT));
        req_valid = '0;
        wait_rsp("single", cyc);
        check("single latency", 512'(cyc), 512'(5));
        check("single rsp_id", 512'(rsp_id), 512'(2));
        check("single rsp_data", 512'(rsp_data), 512'(CT));
        check("single blk_cnt", 512'(blk_cnt), 512'(1));
        step();
        check("single core_in_en_off", 512'(core_in_en), 512'(0));

        // Round-robin table from a fresh reset.
        kill = 1'b1; step(); kill = 1'b0; exp_blk = 0;
        for (int r = 0; r < 14; r++)
            run_txn($sformatf("rr%0d", r), tbl[r].mask, tbl[r].rdy, tbl[r].id);
        req_valid = '0;
        step();
        check("rr blk_cnt", 512'(blk_cnt), 512'(exp_blk));

        // Backpressure: hold response 20 cycles while requester 1 waits.
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        wait_ready("bp");
        check("bp req_ready", 512'(req_ready), 512'(4'b0001));
        step();
        req_valid = 4'b0010;
        wait_rsp("bp", cyc);
        snap_d = rsp_data; snap_id = rsp_id;
        check("bp rsp_data", 512'(snap_d), 512'(exp_ct(rdata[0])));
        bad_a = 0; bad_b = 0; bad_c = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!rsp_valid || rsp_data !== snap_d || rsp_id !== snap_id) bad_a++;
            if (req_ready != '0) bad_b++;
            if (core_in_en) bad_c++;
        end
        check("bp rsp_stable", 512'(bad_a), 512'(0));
        check("bp no_ready", 512'(bad_b), 512'(0));
        check("bp no_issue", 512'(bad_c), 512'(0));
        rsp_ready = 1'b1;
        step();
        check("bp idle", 512'(busy), 512'(0));
        check("bp grant1", 512'(req_ready), 512'(4'b0010));
        step();
        check("bp issue", 512'(core_in_en), 512'(1));
        req_valid = '0;
        wait_rsp("bp2", cyc);
        check("bp2 rsp_id", 512'(rsp_id), 512'(1));
        check("bp2 rsp_data", 512'(rsp_data), 512'(exp_ct(rdata[1])));
        exp_blk += 2;
        check("bp blk_cnt", 512'(blk_cnt), 512'(exp_blk));
        step();

        // Timeout: core never answers.
        core_lat = 0;
        req_valid = 4'b0100;
        wait_ready("to");
        step();
        check("to issue", 512'(core_in_en), 512'(1));
        req_valid = '0;
        n = 0; bad_a = 0;
        while (!err_timeout && n < 30) begin
            step();
            n++;
            if (rsp_valid) bad_a++;
        end
        check("to cycles", 512'(n), 512'(9));
        check("to idle", 512'(busy), 512'(0));
        check("to no_rsp", 512'(bad_a), 512'(0));
        check("to blk_cnt", 512'(blk_cnt), 512'(exp_blk));
        step();
        check("to pulse_width", 512'(err_timeout), 512'(0));

        // Result on the final WAIT cycle wins over the timeout.
        core_lat = 8;
        req_valid = 4'b1000;
        wait_ready("race");
        step();
        req_valid = '0;
        n = 0; bad_a = 0;
        while (!rsp_valid && n < 30) begin
            step();
            n++;
            if (err_timeout) bad_a++;
        end
        check("race cycles", 512'(n), 512'(9));
        check("race no_err", 512'(bad_a), 512'(0));
        check("race rsp_id", 512'(rsp_id), 512'(3));
        check("race rsp_data", 512'(rsp_data), 512'(exp_ct(rdata[3])));
        exp_blk++;
        step();
        check("race err_after", 512'(err_timeout), 512'(0));

        // Spurious result while idle.
        core_lat = 4;
        spur = 1'b1;
        step();
        spur = 1'b0;
        check("spur_idle flag", 512'(err_spurious), 512'(1));
        check("spur_idle no_rsp", 512'({rsp_valid, busy}), 512'(0));
        step();
        check("spur_idle pulse_width", 512'(err_spurious), 512'(0));

        // Spurious result while a response is held must not overwrite it.
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        wait_ready("spur_hold");
        step();
        req_valid = '0;
        wait_rsp("spur_hold", cyc);
        spur = 1'b1;
        step();
        spur = 1'b0;
        check("spur_hold flag", 512'(err_spurious), 512'(1));
        check("spur_hold kept", 512'({rsp_valid, rsp_id, rsp_data}), 512'({1'b1, 2'd0, exp_ct(rdata[0])}));
        exp_blk++;
        check("spur_hold blk_cnt", 512'(blk_cnt), 512'(exp_blk));
        rsp_ready = 1'b1;
        step();

        // No grant while the core reports busy.
        core_idle = 1'b0;
        req_valid = 4'b0010;
        bad_a = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (req_ready != '0) bad_a++;
        end
        check("gate no_ready", 512'(bad_a), 512'(0));
        core_idle = 1'b1;
        #1;
        check("gate ready", 512'(req_ready), 512'(4'b0010));
        step();
        check("gate issue", 512'(core_in_en), 512'(1));
        req_valid = '0;
        wait_rsp("gate", cyc);
        check("gate rsp_id", 512'(rsp_id), 512'(1));
        step();

        // Reset while waiting on the core.
        core_lat = 0;
        req_valid = 4'b0100;
        wait_ready("kw");
        step();
        req_valid = '0;
        step(); step();
        check("kw in_wait", 512'({busy, core_in_en}), 512'(2'b10));
        kill = 1'b1;
        step();
        check("kw reset outputs", 512'(outs()), 512'(0));
        kill = 1'b0;
        bad_a = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (rsp_valid || err_timeout || err_spurious || busy) bad_a++;
        end
        check("kw quiet", 512'(bad_a), 512'(0));

        // Reset while holding a response.
        core_lat = 4;
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        wait_ready("kh");
        check("kh req_ready", 512'(req_ready), 512'(4'b0001));
        step();
        req_valid = '0;
        wait_rsp("kh", cyc);
        kill = 1'b1;
        step();
        check("kh reset outputs", 512'(outs()), 512'(0));
        kill = 1'b0;
        rsp_ready = 1'b1;
        bad_a = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (rsp_valid || err_timeout || err_spurious || busy) bad_a++;
        end
        check("kh quiet", 512'(bad_a), 512'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_128_req_sched.md
# aes_128_req_sched

Round-robin scheduler that shares one AES-128 encryption core between NUM_REQ block requesters. It accepts one 128-bit plaintext block at a time over per-requester valid/ready handshakes and issues it to the core's in_data/in_en input. It then waits for the core's out_en, and returns the ciphertext tagged with the requester index over a backpressured response port. It sits between the system request fabric and the core top level, guaranteeing in_en is never raised while a block is in flight.

## Interface
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 64, max WAIT cycles for core_out_en before abort (≥ 8).

- clk  in  1  clock, all logic on posedge.
- kill  in  1  reset; synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester block valid.
- req_data  in  NUM_REQ*128  per-requester plaintext; requester i at bits [128*i+127:128*i].
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- core_in_data  out  128  block to core.
- core_in_en  out  1  one-cycle start pulse to core.
- core_idle  in  1  core idle flag.
- core_out_data  in  128  core result.
- core_out_en  in  1  core result valid, one-cycle pulse, no backpressure.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_data  out  128  ciphertext.
- rsp_id  out  $clog2(NUM_REQ)  index of originating requester.
- busy  out  1  state ≠ IDLE.
- err_timeout  out  1  one-cycle pulse on WAIT abort.
- err_spurious  out  1  one-cycle pulse on core_out_en outside WAIT.
- blk_cnt  out  16  completed responses, wraps 0xFFFF→0.

## Operation
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - grant g = first index with req_valid set, searching from last_grant+1 upward modulo NUM_REQ.
  - req_ready[g] = 1 combinationally only when some req_valid is set and core_idle=1. All other req_ready bits = 0.
  - On handshake: latch req_data[g] and g, set last_grant=g, go to ISSUE.
  - With core_idle=0, nothing is accepted.
- ISSUE (1 cycle): core_in_en=1, core_in_data=latched block. Clear timeout counter. Go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - core_out_en=1: latch core_out_data into rsp_data and the tag into rsp_id, increment blk_cnt, go to HOLD.
  - Otherwise, when the counter reaches TIMEOUT: pulse err_timeout, go to IDLE, produce no response.
  - core_out_en and counter==TIMEOUT in the same cycle: core_out_en wins, no error.
- HOLD: rsp_valid=1, rsp_data/rsp_id stable. On rsp_ready=1 go to IDLE.
- core_out_en in IDLE, ISSUE or HOLD: data ignored, err_spurious pulses, state unchanged. A held response is never overwritten.
- Counter width is $clog2(TIMEOUT+1). It saturates and does not wrap.
- core_in_data holds its last value outside ISSUE.

## Timing
- Reset (kill=1 at a posedge):
  - state = IDLE, last_grant = NUM_REQ-1 (first grant is index 0).
  - req_ready=0, core_in_en=0, core_in_data=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, err_timeout=0, err_spurious=0, blk_cnt=0, counter=0.
  - Reset mid-operation drops any in-flight or held block without a response and without an error pulse.
- Handshake at edge T: core_in_en=1 during cycle T+1, WAIT from T+2.
- Core result at edge W: rsp_valid=1 from cycle W+1.
- rsp_ready accepted at edge H: IDLE from H+1, where the next req_ready may assert. Back-to-back throughput is therefore handshake → ISSUE → WAIT… → HOLD → IDLE, with a minimum of one IDLE cycle between blocks.
- rsp_ready asserted during the first HOLD cycle is honoured in that cycle.
- req_valid deasserted before grant: no effect. Requesters must hold req_data stable while req_valid=1.
- Fairness: each requester holding req_valid is served within NUM_REQ grants.

## Test plan
- Single request: reset, req_valid[2]=1 with data 0x3243f6a8885a308d313198a2e0370734, core model returns 0x3925841d02dc09fbdc118597196a0b32 four cycles after core_in_en.
  - Expect req_ready=0b0100 for exactly one cycle, core_in_en one cycle later, rsp_valid with rsp_id=2 and that ciphertext, blk_cnt=1.
- Round-robin: all four requesters valid continuously, rsp_ready=1.
  - Expect grant order 0,1,2,3,0,… and each rsp_id matching its grant. After 8 responses, blk_cnt=8.
- Backpressure: rsp_ready=0 for 20 cycles while req_valid[1]=1.
  - Expect rsp_valid and rsp_data stable, no req_ready, no core_in_en. After rsp_ready=1, IDLE, then requester 1 is granted.
- Timeout with TIMEOUT=8: core never answers.
  - Expect err_timeout pulse exactly 8 WAIT cycles after ISSUE, return to IDLE, no rsp_valid, blk_cnt unchanged.
  - Repeat with core_out_en on cycle 8: response produced and no error.
- Spurious/idle gating:
  - core_out_en pulsed in IDLE: one err_spurious pulse, no response.
  - core_idle=0 with req_valid=1: req_ready stays 0 until core_idle=1.
- Reset mid-flight: assert kill in WAIT, and separately in HOLD. Expect every output at its reset value on the next cycle and no response or error afterwards.
